instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the MIPS datapath core. Owns the program counter.
//  Issues word reads to instruction memory over a req/ack handshake and holds each
//  fetched word on instr/instr_pc for the core.
//  Accepts branch/jump redirects from the core's branch logic and squashes stale fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (word aligned)
//  ADDR_W     32             PC / imem address width
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  imem_req       out  1       fetch request valid; held until imem_ack
//  imem_addr      out  ADDR_W  fetch address (= pc); stable while imem_req=1
//  imem_ack       in   1       response strobe; imem_rdata valid this cycle
//  imem_rdata     in   32      instruction word from imem
//  instr          out  32      fetched instruction to datapath
//  instr_pc       out  ADDR_W  address of instr
//  instr_pc4      out  ADDR_W  instr_pc + 4 (for branch target / link)
//  instr_valid    out  1       instr/instr_pc valid
//  instr_ready    in   1       datapath consumes instr this cycle
//  redirect_valid in   1       taken branch/jump this cycle
//  redirect_pc    in   ADDR_W  new PC; bits [1:0] forced to 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, pc=RESET_PC, imem_req=0,
//   imem_addr=RESET_PC, instr=32'h0, instr_pc=RESET_PC, instr_pc4=RESET_PC+4, instr_valid=0.
//  FSM states IDLE, REQ, HOLD, DROP; all registered, Moore outputs.
//  IDLE: one cycle after reset release -> REQ. A redirect here loads pc only.
//   An imem_ack seen here is ignored.
//  REQ: imem_req=1, imem_addr=pc.
//   - ack & !redirect: latch instr=imem_rdata, instr_pc=pc, instr_pc4=pc+4 -> HOLD.
//   - ack & redirect: discard rdata, pc=redirect_pc -> REQ (new request next cycle).
//   - !ack & redirect: pc=redirect_pc -> DROP.
//   - else: stay; address must not change.
//  HOLD: instr_valid=1, imem_req=0.
//   - redirect (priority over instr_ready): drop held word, pc=redirect_pc -> REQ.
//   - instr_ready: pc=pc+4 -> REQ.
//   - else: hold all outputs stable.
//  DROP: imem_req=1 with old address (outstanding request is never withdrawn).
//   Wait for ack and discard rdata -> REQ at the current pc.
//   A further redirect in DROP updates pc and stays in DROP.
//  Exactly one request outstanding; instr_valid=1 only in HOLD. Best-case throughput is
//   one instruction per 2 cycles (REQ, HOLD) with 1-cycle ack.
//  Arithmetic: pc+4 is modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
//   redirect_pc[1:0] is silently zeroed.
//  Reset asserted mid-transaction: immediate return to IDLE and reset values.
//   A late ack from the aborted request arrives in IDLE and is ignored.
//  Simultaneous redirect_valid & instr_ready in HOLD: the redirect wins, instr is not
//   counted as fetched-next, and pc=redirect_pc.
// STRUCTURE
//  Shared package mips_pkg: fetch_state_t enum {IDLE,REQ,HOLD,DROP};
//   localparam PC_STEP=4; localparam INSTR_NOP=32'h0000_0000.
//  One sub-module pc_next_logic: combinational next-pc select from
//   {hold, pc+4, redirect_pc aligned}, with the wrap-around add.
//  FSM, PC register and output registers live in the top module.
// TESTING
//  1 Reset/boot: release reset_n with RESET_PC=0, ack 1 cycle after each req,
//    instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8; instr_valid asserts every 2nd cycle.
//  2 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc, instr_valid stable
//    and imem_req=0; release -> next imem_addr=instr_pc+4.
//  3 Redirect in flight: in REQ, ack delayed 3 cycles, redirect_pc=0x40 pulsed -> DROP.
//    Old ack data is never presented; next imem_addr=0x40; instr_pc=0x40.
//  4 Redirect vs ready: in HOLD with instr_pc=0x10, redirect_valid=1, redirect_pc=0x83,
//    instr_ready=1 -> next imem_addr=0x80.
//  5 Wrap: redirect to 0xFFFF_FFFC, consume -> next imem_addr=0x0000_0000.
//  6 Reset mid-op: assert reset_n=0 in REQ -> same-cycle imem_req=0, instr_valid=0;
//    late ack after release is ignored; first fetch address=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam int          PC_STEP   = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-pc select (hold / pc+4 / aligned redirect)
// Ports:
//   pc             current program counter
//   redirect_valid taken branch/jump; highest priority
//   redirect_pc    redirect target, low two bits ignored
//   advance        step to the sequential next instruction
//   pc_plus4       pc + 4, wrapping modulo 2^ADDR_W
//   pc_next        selected next program counter
module pc_next_logic #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] pc_next
);
    import mips_pkg::*;

    // Truncating add gives the wrap from the top word back to zero for free.
    assign pc_plus4 = pc + ADDR_W'(PC_STEP);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: pc register, imem req/ack, redirect squash
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   imem_req/addr           fetch request, address held until imem_ack
//   imem_ack/rdata          response strobe and instruction word
//   instr/instr_pc/pc4      fetched word, its address, address + 4
//   instr_valid/ready       handshake to the datapath
//   redirect_valid/pc       taken branch/jump from the core
module instr_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc4,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    import mips_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_next;

    pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        ((state == HOLD) && instr_ready),
        .pc_plus4       (pc_plus4),
        .pc_next        (pc_next)
    );

    // pc always follows pc_next: it only differs from pc on a redirect (any
    // state) or a consume in HOLD. imem_addr is a separate register so that
    // it can keep the outstanding address while pc moves on in DROP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= INSTR_NOP;
            instr_pc    <= RESET_PC;
            instr_pc4   <= RESET_PC + ADDR_W'(PC_STEP);
            instr_valid <= 1'b0;
        end else begin
            pc <= pc_next;
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_next;
                end
                REQ: begin
                    if (imem_ack && !redirect_valid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_pc4   <= pc_plus4;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else if (imem_ack) begin
                        // Response is stale; reissue at the redirect target.
                        imem_addr <= pc_next;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_next;
                        instr_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= pc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
